pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (WIDTH >= 1).
REQ-002 Parameter CNT_W, default 16, stall-counter width in bits (CNT_W >= 2).
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Flush  input  1  synchronous flush; discards all buffered beats.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  downstream beat present.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 Count  output  2  occupancy: 0, 1 or 2 beats.
REQ-013 StallCycles  output  CNT_W  count of cycles in which out_valid=1 and out_ready=0.

Function
REQ-014 Input transfer (IT) occurs in a cycle with in_valid=1 and in_ready=1; output transfer (OT) occurs in a cycle with out_valid=1 and out_ready=1.
REQ-015 The stage holds two registered entries, MAIN (drives out_data/out_valid) and SKID; states are EMPTY (Count=0), ONE (Count=1, MAIN valid) and FULL (Count=2).
REQ-016 in_ready shall equal NOT(state==FULL), taken from registered state only; no combinational path from out_ready to in_ready.
REQ-017 out_valid shall be 1 exactly in states ONE and FULL; out_data shall equal MAIN.
REQ-018 EMPTY + IT -> ONE, MAIN<=in_data; out_valid=1 on the following cycle (latency 1 cycle).
REQ-019 ONE + IT + OT -> ONE, MAIN<=in_data.
REQ-020 ONE + OT only -> EMPTY.
REQ-021 ONE + IT only -> FULL, SKID<=in_data, MAIN unchanged.
REQ-022 FULL + OT -> ONE, MAIN<=SKID.
REQ-023 FULL without OT: state and data unchanged.
REQ-024 ONE or FULL without OT: out_data held stable while out_valid=1.
REQ-025 Beats shall leave in arrival order; no beat is lost or duplicated except on Flush.
REQ-026 Flush=1 -> next state EMPTY; MAIN and SKID data cleared to 0.
REQ-027 Flush overrides any IT/OT in the same cycle; the input beat of that cycle is discarded.
REQ-028 The downstream side may observe an OT in the Flush cycle; upstream shall not rely on any beat from that cycle being retained.
REQ-029 StallCycles shall increment by 1 in each cycle with out_valid=1 and out_ready=0.
REQ-030 StallCycles shall saturate at 2^CNT_W-1 and never wrap.
REQ-031 StallCycles is unaffected by Flush.
REQ-032 in_valid is ignored while in_ready=0; in_data is sampled only on IT.

Reset
REQ-033 While Reset=1, all state shall be forced immediately, independent of Clk: state EMPTY, MAIN=0, SKID=0, StallCycles=0.
REQ-034 While Reset=1: out_valid=0, out_data=0, Count=0, in_ready=1.
REQ-035 Reset asserted mid-operation shall drop all buffered beats with no partial update.
REQ-036 The first IT may occur on the first rising edge after Reset deasserts.

Verification
REQ-037 Reset then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0xA5A5A5A5, Count=1.
REQ-038 out_ready=0, send 0x11 then 0x22 -> Count=2, in_ready=0, out_data=0x11; raise out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready=1 after the first OT.
REQ-039 Continuous in_valid=1 and out_ready=1 streaming 0..99 -> 100 beats delivered in order at 1 beat/cycle, Count stays 1, StallCycles=0.
REQ-040 FULL with 0x33/0x44, assert Flush together with in_valid=1, in_data=0x55 -> next cycle Count=0, out_valid=0, out_data=0, 0x55 never appears at the output.
REQ-041 CNT_W=2, hold out_valid=1 with out_ready=0 for 6 cycles -> StallCycles=1,2,3,3,3,3.
REQ-042 Assert Reset asynchronously between edges while FULL -> out_valid=0, Count=0, in_ready=1 before the next Clk edge.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle for both sides of pipe_stage.
// The stage takes the slave modport; the bench or neighbouring logic takes master.
interface pipe_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline stage with flush and a saturating stall counter.
// in_ready comes from registered state only, so out_ready never reaches it combinationally.
module pipe_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Flush,
   pipe_stage_if.slave      bus,
   output logic [1:0]       Count,
   output logic [CNT_W-1:0] StallCycles
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             it, ot;

   assign bus.in_ready  = (state_q != FULL);
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_data  = main_q;
   assign Count         = state_q;
   assign StallCycles   = stall_q;

   assign it = bus.in_valid  & bus.in_ready;
   assign ot = bus.out_valid & bus.out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (it) begin
               state_d = ONE;
               main_d  = bus.in_data;
            end
         end
         ONE: begin
            if (it && ot) begin
               main_d = bus.in_data;
            end else if (ot) begin
               state_d = EMPTY;
            end else if (it) begin
               state_d = FULL;
               skid_d  = bus.in_data;
            end
         end
         FULL: begin
            if (ot) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over any transfer in the same cycle.
      if (Flush) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (bus.out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end
endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: handshake ordering, flush, async reset, stall saturation.
module tb_pipe_stage;
   logic        Clk = 1'b0;
   logic        Reset;
   logic        Flush;
   logic [1:0]  cnt0, cnt1;
   logic [15:0] stall0;
   logic [1:0]  stall1;
   int          n_chk = 0;
   int          n_err = 0;

   pipe_stage_if #(.WIDTH(32)) if0 ();
   pipe_stage_if #(.WIDTH(32)) if1 ();

   pipe_stage #(.WIDTH(32), .CNT_W(16)) u0 (
      .Clk(Clk), .Reset(Reset), .Flush(Flush), .bus(if0.slave),
      .Count(cnt0), .StallCycles(stall0)
   );

   pipe_stage #(.WIDTH(32), .CNT_W(2)) u1 (
      .Clk(Clk), .Reset(Reset), .Flush(Flush), .bus(if1.slave),
      .Count(cnt1), .StallCycles(stall1)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   logic [31:0] exp_stall1 [6];

   initial begin
      exp_stall1[0] = 1; exp_stall1[1] = 2; exp_stall1[2] = 3;
      exp_stall1[3] = 3; exp_stall1[4] = 3; exp_stall1[5] = 3;

      Reset = 1'b1; Flush = 1'b0;
      if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
      if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, if0.out_valid}, 0);
      chk("rst_out_data",  if0.out_data, 0);
      chk("rst_count",     {30'd0, cnt0}, 0);
      chk("rst_in_ready",  {31'd0, if0.in_ready}, 1);
      chk("rst_stall",     {16'd0, stall0}, 0);
      step(); step();
      Reset = 1'b0;

      // single beat, latency 1
      if0.in_valid = 1'b1; if0.in_data = 32'hA5A5A5A5; if0.out_ready = 1'b1;
      step();
      if0.in_valid = 1'b0;
      chk("lat_out_valid", {31'd0, if0.out_valid}, 1);
      chk("lat_out_data",  if0.out_data, 32'hA5A5A5A5);
      chk("lat_count",     {30'd0, cnt0}, 1);
      step();
      chk("lat_drain_count", {30'd0, cnt0}, 0);

      // fill to FULL, then drain in order
      if0.out_ready = 1'b0;
      if0.in_valid = 1'b1; if0.in_data = 32'h11;
      step();
      chk("fill1_count", {30'd0, cnt0}, 1);
      if0.in_data = 32'h22;
      step();
      if0.in_valid = 1'b0;
      chk("full_count",    {30'd0, cnt0}, 2);
      chk("full_in_ready", {31'd0, if0.in_ready}, 0);
      chk("full_out_data", if0.out_data, 32'h11);
      chk("full_stall",    {16'd0, stall0}, 1);
      if0.out_ready = 1'b1;
      step();
      chk("drain1_data",     if0.out_data, 32'h22);
      chk("drain1_in_ready", {31'd0, if0.in_ready}, 1);
      chk("drain1_count",    {30'd0, cnt0}, 1);
      step();
      chk("drain2_out_valid", {31'd0, if0.out_valid}, 0);
      chk("drain_stall",      {16'd0, stall0}, 1);

      // full-rate streaming
      if0.in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if0.in_data = i;
         step();
         chk("stream_data",  if0.out_data, i);
         chk("stream_count", {30'd0, cnt0}, 1);
      end
      if0.in_valid = 1'b0;
      step();
      chk("stream_end_valid", {31'd0, if0.out_valid}, 0);
      chk("stream_stall",     {16'd0, stall0}, 1);

      // flush while FULL discards the concurrent input beat
      if0.out_ready = 1'b0;
      if0.in_valid = 1'b1; if0.in_data = 32'h33;
      step();
      if0.in_data = 32'h44;
      step();
      chk("pre_flush_count", {30'd0, cnt0}, 2);
      Flush = 1'b1; if0.in_data = 32'h55;
      step();
      Flush = 1'b0; if0.in_valid = 1'b0;
      chk("flush_count",     {30'd0, cnt0}, 0);
      chk("flush_out_valid", {31'd0, if0.out_valid}, 0);
      chk("flush_out_data",  if0.out_data, 0);
      chk("flush_stall",     {16'd0, stall0}, 3);
      if0.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_flush_valid", {31'd0, if0.out_valid}, 0);
      end

      // asynchronous reset between edges while FULL
      if0.out_ready = 1'b0;
      if0.in_valid = 1'b1; if0.in_data = 32'h66;
      step();
      if0.in_data = 32'h77;
      step();
      if0.in_valid = 1'b0;
      chk("pre_rst_count", {30'd0, cnt0}, 2);
      #2 Reset = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, if0.out_valid}, 0);
      chk("arst_count",     {30'd0, cnt0}, 0);
      chk("arst_in_ready",  {31'd0, if0.in_ready}, 1);
      chk("arst_out_data",  if0.out_data, 0);
      chk("arst_stall",     {16'd0, stall0}, 0);
      #2 Reset = 1'b0;

      // first edge after reset accepts a beat
      if0.in_valid = 1'b1; if0.in_data = 32'h88;
      step();
      if0.in_valid = 1'b0;
      chk("post_rst_valid", {31'd0, if0.out_valid}, 1);
      chk("post_rst_data",  if0.out_data, 32'h88);

      // 2-bit stall counter saturates
      if1.in_valid = 1'b1; if1.in_data = 32'h9;
      step();
      if1.in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("sat_stall", {30'd0, stall1}, exp_stall1[i]);
      end
      chk("sat_count", {30'd0, cnt1}, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
